// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and encodings for the multicycle MIPS control.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int ALU_CTRL_WIDTH = 3;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11
    } mips_mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_alu_decoder
//  Description : Maps aluop/funct to the ALU control code; flags legal functs.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0]                i_aluop,
    input  logic [5:0]                i_funct,
    output logic [ALU_CTRL_WIDTH-1:0] o_alucontrl,
    output logic                      o_funct_ok
);

    logic [ALU_CTRL_WIDTH-1:0] w_funct_ctrl;

    // Legality is reported independently of aluop so DECODE can use it.
    always_comb begin
        w_funct_ctrl = ALU_ADD;
        o_funct_ok   = 1'b1;
        case (i_funct)
            FN_ADD, FN_NOP: w_funct_ctrl = ALU_ADD;
            FN_SUB:         w_funct_ctrl = ALU_SUB;
            FN_AND:         w_funct_ctrl = ALU_AND;
            FN_OR:          w_funct_ctrl = ALU_OR;
            FN_SLT:         w_funct_ctrl = ALU_SLT;
            default: begin
                w_funct_ctrl = ALU_ADD;
                o_funct_ok   = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_alucontrl = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:   o_alucontrl = ALU_ADD;
            ALUOP_SUB:   o_alucontrl = ALU_SUB;
            ALUOP_FUNCT: o_alucontrl = w_funct_ctrl;
            default:     o_alucontrl = ALU_ADD;
        endcase
    end

endmodule : mips_alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multicycle MIPS sequencer with memory-ready wait/timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5:0]                i_opcode,
    input  logic [5:0]                i_funct,
    input  logic                      i_zero,
    input  logic                      i_mem_ready,
    output logic                      o_iord,
    output logic                      o_memwrite,
    output logic                      o_irwrite,
    output logic                      o_regdst,
    output logic                      o_memtoreg,
    output logic                      o_regwrite,
    output logic                      o_alusrca,
    output logic [1:0]                o_alusrcb,
    output logic [1:0]                o_pcsrc,
    output logic                      o_pcen,
    output logic [ALU_CTRL_WIDTH-1:0] o_alucontrl,
    output logic                      o_illegal,
    output logic                      o_mem_timeout
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(WAIT_MAX);

    mips_mc_state_t r_state;
    mips_mc_state_t w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic       w_mem_state;
    logic       w_timeout;
    logic       w_funct_ok;
    logic       w_opcode_ok;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;

    mips_alu_decoder u_alu_decoder (
        .i_aluop     (w_aluop),
        .i_funct     (i_funct),
        .o_alucontrl (o_alucontrl),
        .o_funct_ok  (w_funct_ok)
    );

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                         (r_state == ST_MEMWR);
    // The limit is hit on the cycle the counter would step to WAIT_MAX,
    // so a stalled access spans exactly WAIT_MAX cycles.
    assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == c_cnt_last);

    always_comb begin
        w_opcode_ok = 1'b0;
        case (i_opcode)
            OP_RTYPE:                            w_opcode_ok = w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_opcode_ok = 1'b1;
            default:                             w_opcode_ok = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_mem_state && !i_mem_ready && (r_wait_cnt != c_cnt_max)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (i_mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (i_opcode)
                    OP_RTYPE: w_next_state = w_funct_ok ? ST_EXECUTE : ST_FETCH;
                    OP_LW,
                    OP_SW:    w_next_state = ST_MEMADR;
                    OP_BEQ:   w_next_state = ST_BRANCH;
                    OP_ADDI:  w_next_state = ST_ADDIEX;
                    OP_J:     w_next_state = ST_JUMP;
                    default:  w_next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR:  w_next_state = (i_opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (i_mem_ready)    w_next_state = ST_MEMWB;
                else if (w_timeout) w_next_state = ST_FETCH;
            end
            ST_MEMWR: begin
                if (i_mem_ready || w_timeout) w_next_state = ST_FETCH;
            end
            ST_EXECUTE: w_next_state = ST_ALUWB;
            ST_ADDIEX:  w_next_state = ST_ADDIWB;
            ST_MEMWB,
            ST_ALUWB,
            ST_BRANCH,
            ST_ADDIWB,
            ST_JUMP:    w_next_state = ST_FETCH;
            default:    w_next_state = ST_FETCH;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        o_iord     = 1'b0;
        o_memwrite = 1'b0;
        o_irwrite  = 1'b0;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = SRCB_RT;
        o_pcsrc    = PCSRC_ALU;
        o_illegal  = 1'b0;
        w_aluop    = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_alusrcb = SRCB_FOUR;
                o_irwrite = i_mem_ready;
                w_pcwrite = i_mem_ready;
            end
            ST_DECODE: begin
                o_alusrcb = SRCB_IMMSH;
                o_illegal = !w_opcode_ok;
            end
            ST_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            ST_MEMRD:  o_iord = 1'b1;
            ST_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            ST_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
            end
            ST_EXECUTE: begin
                o_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            ST_BRANCH: begin
                o_alusrca = 1'b1;
                o_pcsrc   = PCSRC_ALUOUT;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            ST_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            ST_ADDIWB: o_regwrite = 1'b1;
            ST_JUMP: begin
                o_pcsrc   = PCSRC_JUMP;
                w_pcwrite = 1'b1;
            end
            default: o_alusrcb = SRCB_FOUR;
        endcase
    end

    assign o_pcen        = w_pcwrite | (w_branch & i_zero);
    assign o_mem_timeout = w_timeout;

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Randomized instruction-level bench for mips_multicycle_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] i_opcode = 6'd0;
    logic [5:0] i_funct = 6'd0;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b0;
    logic       o_iord, o_memwrite, o_irwrite, o_regdst, o_memtoreg, o_regwrite;
    logic       o_alusrca, o_pcen, o_illegal, o_mem_timeout;
    logic [1:0] o_alusrcb, o_pcsrc;
    logic [2:0] o_alucontrl;

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_opcode      (i_opcode),
        .i_funct       (i_funct),
        .i_zero        (i_zero),
        .i_mem_ready   (i_mem_ready),
        .o_iord        (o_iord),
        .o_memwrite    (o_memwrite),
        .o_irwrite     (o_irwrite),
        .o_regdst      (o_regdst),
        .o_memtoreg    (o_memtoreg),
        .o_regwrite    (o_regwrite),
        .o_alusrca     (o_alusrca),
        .o_alusrcb     (o_alusrcb),
        .o_pcsrc       (o_pcsrc),
        .o_pcen        (o_pcen),
        .o_alucontrl   (o_alucontrl),
        .o_illegal     (o_illegal),
        .o_mem_timeout (o_mem_timeout)
    );

    always #5 clk = ~clk;

    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrl,illegal,timeout}
    wire [16:0] w_obs = {o_iord, o_memwrite, o_irwrite, o_regdst, o_memtoreg, o_regwrite,
                         o_alusrca, o_alusrcb, o_pcsrc, o_pcen, o_alucontrl, o_illegal,
                         o_mem_timeout};

    task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input bit iord, input bit mw, input bit irw, input bit rd,
                                       input bit mtr, input bit rw, input bit asa,
                                       input logic [1:0] asb, input logic [1:0] ps, input bit pcen,
                                       input logic [2:0] alu, input bit ill, input bit to);
        return {iord, mw, irw, rd, mtr, rw, asa, asb, ps, pcen, alu, ill, to};
    endfunction

    function automatic bit funct_legal(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b000000 || fn == 6'b100010 ||
               fn == 6'b100100 || fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit instr_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return funct_legal(fn);
            6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Entered just after a rising edge; checks on the falling edge.
    task automatic cyc(input string tag, input bit mr, input logic [16:0] exp);
        i_mem_ready = mr;
        @(negedge clk);
        check_val(tag, w_obs, exp);
        @(posedge clk);
        #1;
    endtask

    // A memory-waiting phase: ready arrives after 'waits' stalled cycles,
    // unless the stall hits WAIT_MAX cycles first.
    task automatic mem_phase(input string tag, input bit is_wr, input int waits, output bit timed_out);
        timed_out = 1'b0;
        for (int c = 0; c < WAIT_MAX; c++) begin
            bit mr, to;
            mr = (c == waits);
            to = !mr && (c == WAIT_MAX - 1);
            cyc(tag, mr, mk(1, is_wr, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, to));
            timed_out = to;
            if (mr || to) break;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int fw, input int mw);
        bit done, timed;
        int waits;
        i_opcode = op;
        i_funct  = fn;
        i_zero   = z;
        done     = 1'b0;
        waits    = fw;
        while (!done) begin
            for (int c = 0; c < WAIT_MAX; c++) begin
                bit mr, to;
                mr = (c == waits);
                to = !mr && (c == WAIT_MAX - 1);
                cyc("fetch", mr, mk(0, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, mr, 3'b010, 0, to));
                if (mr) begin
                    done = 1'b1;
                    break;
                end
            end
            waits = 0;
        end
        cyc("decode", 1'($urandom_range(0, 1)),
            mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, !instr_legal(op, fn), 0));
        if (!instr_legal(op, fn)) return;
        case (op)
            6'b100011: begin
                cyc("memadr", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0));
                mem_phase("memrd", 1'b0, mw, timed);
                if (!timed)
                    cyc("memwb", 1'($urandom_range(0, 1)),
                        mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0));
            end
            6'b101011: begin
                cyc("memadr", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0));
                mem_phase("memwr", 1'b1, mw, timed);
            end
            6'b000000: begin
                cyc("execute", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, alu_of(fn), 0, 0));
                cyc("aluwb", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0));
            end
            6'b000100:
                cyc("branch", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, z, 3'b110, 0, 0));
            6'b001000: begin
                cyc("addiex", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0));
                cyc("addiwb", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0));
            end
            default:
                cyc("jump", 1'($urandom_range(0, 1)),
                    mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b010, 0, 0));
        endcase
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(14, 16));
        return int'($urandom_range(0, 2));
    endfunction

    localparam logic [16:0] c_fetch_idle = 17'b0_0_0_0_0_0_0_01_00_0_010_0_0;

    initial begin
        logic [5:0] op, fn;
        bit timed;
        #3;
        check_val("reset_outputs", w_obs, c_fetch_idle);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("post_reset", 1'b0, c_fetch_idle);

        // Abort a store mid-wait with reset.
        i_opcode = 6'b101011;
        cyc("rst_fetch", 1'b1, mk(0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3'b010, 0, 0));
        cyc("rst_decode", 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, 0));
        cyc("rst_memadr", 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc("rst_memwr", 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0));
        #2 rst = 1'b1;
        #1 check_val("rst_memwrite_drop", {16'd0, o_memwrite}, 17'd0);
        check_val("rst_during", w_obs, c_fetch_idle);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("rst_release", w_obs, c_fetch_idle);
        @(posedge clk);
        #1;
        cyc("rst_after", 1'b0, c_fetch_idle);

        // Directed cases: LW latency, BEQ taken/not, SLT, bad funct, SW timeout, late ready.
        run_instr(6'b100011, 6'd0, 1'b0, 0, 0);
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
        run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
        run_instr(6'b101011, 6'd0, 1'b0, 0, 100);
        run_instr(6'b100011, 6'd0, 1'b0, 0, 14);
        run_instr(6'b001000, 6'd0, 1'b0, 20, 0);
        run_instr(6'b000010, 6'd0, 1'b0, 14, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: begin
                    op = 6'b000000;
                    case ($urandom_range(0, 5))
                        0: fn = 6'b100000;
                        1: fn = 6'b000000;
                        2: fn = 6'b100010;
                        3: fn = 6'b100100;
                        4: fn = 6'b100101;
                        default: fn = 6'b101010;
                    endcase
                end
                1: begin op = 6'b000000; fn = 6'($urandom); end
                2, 8: begin op = 6'b100011; fn = 6'($urandom); end
                3, 9: begin op = 6'b101011; fn = 6'($urandom); end
                4: begin op = 6'b000100; fn = 6'($urandom); end
                5: begin op = 6'b001000; fn = 6'($urandom); end
                6: begin op = 6'b000010; fn = 6'($urandom); end
                default: begin op = 6'($urandom); fn = 6'($urandom); end
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), rand_wait(), rand_wait());
        end
        cyc("final_fetch", 1'b0, c_fetch_idle);
        timed = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire
